// File: rtl/multi_freq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_freq_counter_pkg
// Brief    : Shared constants and the saturating-increment helper used by the
//            multi-channel frequency counter.
// Revision : 1.0  initial release
// ============================================================================
package multi_freq_counter_pkg;

    // Measurement mode encodings driven on the top-level mode input.
    localparam logic MODE_HIGH   = 1'b0;  // count ticks while input is high
    localparam logic MODE_PERIOD = 1'b1;  // count ticks between rising edges

    // Saturating increment for an accumulator of 'width' bits (width <= 32).
    // The value is carried zero-extended in 32 bits; the caller truncates back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_val;
        if (width >= 32) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        if (value >= max_val) begin
            return max_val;
        end
        return value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_channel.sv
`default_nettype none
// ============================================================================
// Module   : freq_channel
// Brief    : One measurement channel: 2-flop synchroniser, edge detector,
//            saturating tick accumulator and latched result with flags.
// Revision : 1.0  initial release
// ============================================================================
module freq_channel
    import multi_freq_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_i,
    input  logic             mode_i,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] ACC_MAX = '1;

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             sat_q,   sat_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             ovf_q,   ovf_d;

    logic             rise;
    logic             fall;
    logic             latch_edge;

    // Synchroniser and edge-history flops run regardless of enable so that
    // re-enabling never produces a stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Accumulate on ticks, latch on the mode-selected edge; a latching edge
    // takes priority over a coincident tick so the tick is discarded.
    always_comb begin
        acc_d   = acc_q;
        sat_d   = sat_q;
        count_d = count_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;

        rise       = sync2_q & ~prev_q;
        fall       = ~sync2_q & prev_q;
        latch_edge = (mode_i == MODE_PERIOD) ? rise : fall;

        if (clear_i) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (enable_i && latch_edge) begin
            if (acc_q != '0) begin
                count_d = acc_q;
                valid_d = 1'b1;
                ovf_d   = sat_q;
            end
            acc_d = '0;
            sat_d = 1'b0;
        end else if (tick_i && ((mode_i == MODE_PERIOD) || sync2_q)) begin
            acc_d = WIDTH'(sat_inc(32'(acc_q), WIDTH));
            if (acc_q == ACC_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    // Measurement state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/multi_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : multi_freq_counter
// Brief    : CHANNELS independent high-phase / period counters sharing one
//            prescaled tick enable and one mode-change clear.
// Revision : 1.0  initial release
// ============================================================================
module multi_freq_counter
    import multi_freq_counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 250,
    parameter int PS_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       ip_signal,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       ovf
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;
    logic            mode_q;
    logic            mode_clear;

    // Prescaler: wraps at PRESCALE-1 and freezes (not clears) while disabled.
    always_comb begin
        ps_d = ps_q;
        tick = 1'b0;
        if (enable) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                tick = 1'b1;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    // Prescaler and previous-mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q   <= '0;
            mode_q <= MODE_HIGH;
        end else begin
            ps_q   <= ps_d;
            mode_q <= mode;
        end
    end

    // Any mode change restarts every accumulator on the following edge.
    assign mode_clear = (mode != mode_q);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            freq_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .sig_i    (ip_signal[i]),
                .mode_i   (mode),
                .enable_i (enable),
                .tick_i   (tick),
                .clear_i  (mode_clear),
                .count_o  (count[i*WIDTH +: WIDTH]),
                .valid_o  (valid[i]),
                .ovf_o    (ovf[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_freq_counter
// Brief    : Randomised self-checking bench with a cycle-indexed behavioural
//            model (input history array + unbounded tick counts, clipped on
//            report).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_freq_counter;

    localparam int CH   = 4;
    localparam int W    = 5;
    localparam int PS   = 4;
    localparam int PSW  = 2;
    localparam int MAXC = 16384;
    localparam int SAT  = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic            enable;
    logic [CH-1:0]   ip_signal;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   valid;
    logic [CH-1:0]   ovf;

    always #5 clk = ~clk;

    multi_freq_counter #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .PRESCALE (PS),
        .PS_W     (PSW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .enable    (enable),
        .ip_signal (ip_signal),
        .count     (count),
        .valid     (valid),
        .ovf       (ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH-1:0] hist [MAXC];
    int            k         = 0;
    int            base      = 0;
    int            en_count  = 0;
    logic          mode_prev = 1'b0;
    int            acc_n   [CH];
    logic [W-1:0]  e_cnt   [CH];
    logic [CH-1:0] e_valid = '0;
    logic [CH-1:0] e_ovf   = '0;

    // Value of the input as sampled at edge idx, zero before the last reset.
    function automatic logic sig_at(input int idx, input int ch);
        if (idx < base || idx < 0 || idx >= MAXC) return 1'b0;
        return hist[idx][ch];
    endfunction

    // One clock edge of the model: the counting logic sees the input two
    // edges late, and an edge is a difference between consecutive samples.
    task automatic model_edge();
        logic tick_m, clr, s, p, hit;
        if (k < MAXC) hist[k] = ip_signal;
        e_valid = '0;
        if (!rst_n) begin
            base      = k + 1;
            en_count  = 0;
            mode_prev = 1'b0;
            e_ovf     = '0;
            for (int c = 0; c < CH; c++) begin
                acc_n[c] = 0;
                e_cnt[c] = '0;
            end
        end else begin
            tick_m = enable && ((en_count % PS) == PS - 1);
            if (enable) en_count++;
            clr       = (mode != mode_prev);
            mode_prev = mode;
            for (int c = 0; c < CH; c++) begin
                s   = sig_at(k - 2, c);
                p   = sig_at(k - 3, c);
                hit = mode ? (s && !p) : (!s && p);
                if (clr) begin
                    acc_n[c] = 0;
                end else if (enable && hit) begin
                    if (acc_n[c] > 0) begin
                        e_cnt[c]   = (acc_n[c] > SAT) ? W'(SAT) : W'(acc_n[c]);
                        e_ovf[c]   = (acc_n[c] > SAT);
                        e_valid[c] = 1'b1;
                    end
                    acc_n[c] = 0;
                end else if (tick_m && (mode || s)) begin
                    acc_n[c]++;
                end
            end
        end
        k++;
    endtask

    task automatic compare_outputs();
        logic [CH*W-1:0] eb;
        for (int c = 0; c < CH; c++) eb[c*W +: W] = e_cnt[c];
        check("valid", valid, e_valid);
        check("count", count, eb);
        check("ovf", ovf, e_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    // ---------------- random stimulus ----------------
    int remain [CH];
    int dmin = 1;
    int dmax = 60;

    task automatic drive_random();
        for (int c = 0; c < CH; c++) begin
            if (remain[c] <= 0) begin
                ip_signal[c] = ~ip_signal[c];
                remain[c]    = int'($urandom_range(dmax, dmin));
            end
            remain[c]--;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        enable    = 1'b0;
        ip_signal = '0;
        for (int c = 0; c < CH; c++) begin
            remain[c] = 0;
            acc_n[c]  = 0;
            e_cnt[c]  = '0;
        end

        step();
        step();
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", ovf, 0);

        rst_n = 1'b1;
        step();
        step();

        // High phase of 40 clk on ch0 from an aligned prescaler: 10 ticks.
        enable       = 1'b1;
        ip_signal[0] = 1'b1;
        repeat (40) step();
        ip_signal[0] = 1'b0;
        repeat (3) step();
        check("tp1_valid", valid[0], 1);
        check("tp1_count", count[W-1:0], 10);
        check("tp1_ovf", ovf[0], 0);
        step();
        check("tp1_pulse_once", valid[0], 0);

        // Random high/low phases in mode 0.
        dmin = 1;
        dmax = 60;
        repeat (1500) begin
            drive_random();
            step();
        end

        // Long high phase on ch2 saturates the accumulator.
        ip_signal[2] = 1'b1;
        repeat (200) step();
        ip_signal[2] = 1'b0;
        repeat (3) step();
        check("sat_valid", valid[2], 1);
        check("sat_count", count[2*W +: W], SAT);
        check("sat_ovf", ovf[2], 1);

        // Any 12 consecutive enabled clk contain exactly 3 ticks.
        repeat (10) step();
        ip_signal[2] = 1'b1;
        repeat (12) step();
        ip_signal[2] = 1'b0;
        repeat (3) step();
        check("short_valid", valid[2], 1);
        check("short_count", count[2*W +: W], 3);
        check("short_ovf", ovf[2], 0);

        // Period mode with random waveforms.
        mode = 1'b1;
        dmin = 4;
        dmax = 40;
        repeat (1500) begin
            drive_random();
            step();
        end

        // Random enable gaps and mode flips.
        dmin = 1;
        dmax = 40;
        repeat (2500) begin
            if ($urandom_range(19, 0) == 0) enable = ~enable;
            if ($urandom_range(299, 0) == 0) mode = ~mode;
            drive_random();
            step();
        end

        // Asynchronous reset mid-measurement.
        enable = 1'b1;
        mode   = 1'b0;
        repeat (37) begin
            drive_random();
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", valid, 0);
        check("arst_ovf", ovf, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (500) begin
            drive_random();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
